egress_arb72: RTL
=================

# egress_arb72

Two-into-one frame-granular round-robin arbiter for the 72-bit FIFO word stream. It reads two upstream receive FIFOs (standard read, one-cycle read latency) and presents one FIFO-style read port to the downstream fifo72toxgmii transmit converter. Whole frames are forwarded without interleaving, which lets more than one ingress port share an egress port.

## Interface
Parameters:
- QDEPTH_LOG2, 3: output queue depth is 2^QDEPTH_LOG2 words.

Ports:
- sys_clk  in  1  single clock for all logic.
- sys_rst  in  1  synchronous, active-high reset.
- in0_dout  in  72  upstream FIFO 0 read data, valid the cycle after in0_rd_en.
- in0_empty  in  1  upstream FIFO 0 empty.
- in0_rd_en  out  1  upstream FIFO 0 read strobe.
- in1_dout, in1_empty, in1_rd_en: same as port 0, for upstream FIFO 1.
- dout  out  72  downstream read data, valid the cycle after an accepted rd_en.
- empty  out  1  high when the output queue is empty.
- rd_en  in  1  downstream read strobe. Ignored while empty=1.
- frames0, frames1  out  32 each  count of frames forwarded from each port. Wraps at 2^32.

## Operation
- Word format:
  - [63:0] is data; [71:64] is a lane-valid mask, contiguous from lane 0.
  - A word with mask != 8'hFF is end-of-frame (EOF). Frames whose length is a multiple of 8 bytes end with a mask 8'h00 word.
  - The arbiter forwards every word unmodified.
- State machine: IDLE, GRANT0, GRANT1.
  - A port requests when its FIFO is not empty or its hold register is valid.
  - In IDLE, pick the requesting port that is not last_grant. If only one port requests, pick that one. last_grant resets to 1, so port 0 wins the first tie.
  - Leaving IDLE takes 1 cycle. The arbiter then stays in GRANTx until the EOF word of the frame enters the output queue, then returns to IDLE.
  - No preemption. If the granted FIFO empties mid-frame, the grant is held indefinitely.
- Reads during a grant:
  - If hold_v[x] is set, the hold word goes into the queue first, with no FIFO read.
  - After that, in*_rd_en is asserted each cycle the FIFO is not empty and count + inflight <= 2^QDEPTH_LOG2 - 2.
- Overread: reads are pipelined, so at most one word past the EOF may already be in flight when the EOF returns.
  - That word goes into per-port hold register hold[x] with hold_v[x] set. It does not go into the queue.
  - It becomes the first word of that port's next grant.
- frames{x} increments by 1 on the cycle the EOF word from port x is written to the queue.
- Output queue:
  - On rd_en && !empty, dout is loaded with the head word on the next edge and count decrements.
  - Simultaneous write and read leave count unchanged.
  - The queue never overflows; the room check guarantees this.

## Timing
- Reset values: in0_rd_en=0, in1_rd_en=0, dout=0, empty=1, frames0=frames1=0, state IDLE, hold_v=0, count=0, last_grant=1.
- Reset mid-frame discards the queue, hold registers and in-flight reads. Upstream words already popped are lost. The first output after reset is a fresh arbitration.
- Latency, with empty queue and idle arbiter:
  - Input not empty at cycle t.
  - Grant registered at t+1; rd_en issued at t+1.
  - Word written to the queue at t+2.
  - empty falls at t+3.
  - dout is valid the cycle after the downstream rd_en.
- Throughput: one word per cycle within a frame when the queue has room.
- Frame-to-frame gap: EOF write at cycle e, state IDLE at e+1, next grant at e+2. At least one bubble cycle per frame.
- in*_rd_en is never asserted while the matching in*_empty=1, nor for the non-granted port.

## Test plan
- Single frame on port 0: 3 words, masks FF,FF,0F. Required: identical 3 words on dout in order; frames0=1; empty returns to 1; in1_rd_en never asserted.
- Both ports continuously loaded with 4-word frames (masks FF,FF,FF,03), tagged data. Required: output alternates port0 frame, port1 frame, port0 frame, …; frames never interleaved; frames0 and frames1 differ by at most 1.
- Back-to-back frames on port 1 only, downstream rd_en held high. Required: the overread word lands in hold; the next frame starts with it; there is no loss or duplication across 100 frames, checked by sequence number in data.
- Downstream rd_en held low for 50 cycles during a 20-word frame. Required: in*_rd_en throttles when the queue is nearly full; no queue overflow; all 20 words delivered after rd_en resumes.
- Granted FIFO goes empty mid-frame while the other port has data. Required: the grant holds; no port-1 words appear until port 0's EOF arrives.
- Assert sys_rst for 1 cycle mid-frame. Required: all outputs return to their reset values on the next cycle; the next frame is forwarded intact.

Source files
------------

// File: rtl/egress_arb72.sv
// egress_arb72: two-input, frame-granular round-robin arbiter for the 72-bit
// FIFO word stream. Whole frames from either upstream FIFO are copied into a
// small output queue that downstream reads like a standard FIFO.
module egress_arb72 #(
    parameter int QDEPTH_LOG2 = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [71:0] in0_dout,
    input  logic        in0_empty,
    output logic        in0_rd_en,
    input  logic [71:0] in1_dout,
    input  logic        in1_empty,
    output logic        in1_rd_en,
    output logic [71:0] dout,
    output logic        empty,
    input  logic        rd_en,
    output logic [31:0] frames0,
    output logic [31:0] frames1
);
    localparam int DEPTH = 1 << QDEPTH_LOG2;
    localparam int CW    = QDEPTH_LOG2 + 1;
    // Issue a read only if the queue can take both the word already in
    // flight and the one being requested now.
    localparam logic [CW:0] ROOM_MAX = (CW + 1)'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic [1:0]             hold_v_q, hold_v_d;
    logic [1:0][71:0]       hold_q, hold_d;
    logic                   rd_v_q, rd_v_d;       // a FIFO read returns data this cycle
    logic                   rd_port_q, rd_port_d; // which FIFO that read went to
    logic [CW-1:0]          count_q, count_d;
    logic [QDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [71:0]            dout_q, dout_d;
    logic [1:0][31:0]       frames_q, frames_d;
    logic [71:0]            mem_q [DEPTH];

    logic [1:0][71:0] in_dout;
    logic [1:0]       in_empty, req, fifo_rd;
    logic             gnt_v, gnt_port, room, wr_en, wr_eof, rd_acc;
    logic [71:0]      wr_data;
    logic [CW:0]      occ;

    // Arbitration, word routing (queue vs. hold), read issue and queue pointers
    always_comb begin
        in_dout      = {in1_dout, in0_dout};
        in_empty     = {in1_empty, in0_empty};
        gnt_v        = (state_q != IDLE);
        gnt_port     = (state_q == GRANT1);
        req          = ~in_empty | hold_v_q;
        occ          = {1'b0, count_q} + (CW + 1)'(rd_v_q);
        room         = (occ <= ROOM_MAX);

        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_v_d     = hold_v_q;
        hold_d       = hold_q;
        frames_d     = frames_q;
        fifo_rd      = 2'b00;
        wr_en        = 1'b0;
        wr_data      = in_dout[rd_port_q];

        // A returning word belongs to the current frame only while its port
        // is still granted; otherwise it is the overread past an EOF.
        if (rd_v_q) begin
            if (gnt_v && (gnt_port == rd_port_q)) begin
                wr_en = 1'b1;
            end else begin
                hold_d[rd_port_q]   = in_dout[rd_port_q];
                hold_v_d[rd_port_q] = 1'b1;
            end
        end else if (gnt_v && hold_v_q[gnt_port] && !count_q[CW-1]) begin
            wr_en              = 1'b1;
            wr_data            = hold_q[gnt_port];
            hold_v_d[gnt_port] = 1'b0;
        end

        // The hold word must go first, so no FIFO read while it is pending.
        if (gnt_v && !hold_v_q[gnt_port] && !in_empty[gnt_port] && room)
            fifo_rd[gnt_port] = 1'b1;

        wr_eof = wr_en && (wr_data[71:64] != 8'hFF);
        if (wr_eof)
            frames_d[gnt_port] = frames_q[gnt_port] + 32'd1;

        case (state_q)
            IDLE: begin
                if (req[0] && (!req[1] || last_grant_q)) begin
                    state_d      = GRANT0;
                    last_grant_d = 1'b0;
                end else if (req[1]) begin
                    state_d      = GRANT1;
                    last_grant_d = 1'b1;
                end
            end
            default: if (wr_eof) state_d = IDLE;
        endcase

        rd_v_d    = |fifo_rd;
        rd_port_d = fifo_rd[1];

        rd_acc   = rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q + QDEPTH_LOG2'(wr_en);
        rd_ptr_d = rd_ptr_q + QDEPTH_LOG2'(rd_acc);
        count_d  = count_q + CW'(wr_en) - CW'(rd_acc);
        dout_d   = rd_acc ? mem_q[rd_ptr_q] : dout_q;
    end

    // State register with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            hold_v_q     <= '0;
            hold_q       <= '0;
            rd_v_q       <= 1'b0;
            rd_port_q    <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            dout_q       <= '0;
            frames_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            hold_v_q     <= hold_v_d;
            hold_q       <= hold_d;
            rd_v_q       <= rd_v_d;
            rd_port_q    <= rd_port_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dout_q       <= dout_d;
            frames_q     <= frames_d;
        end
    end

    // Queue storage; contents are meaningless once the pointers reset
    always_ff @(posedge sys_clk) begin
        if (wr_en && !sys_rst)
            mem_q[wr_ptr_q] <= wr_data;
    end

    assign in0_rd_en = fifo_rd[0];
    assign in1_rd_en = fifo_rd[1];
    assign dout      = dout_q;
    assign empty     = (count_q == '0);
    assign frames0   = frames_q[0];
    assign frames1   = frames_q[1];
endmodule
